// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. It uses one full-adder slice and a carry
//   flop, and processes WIDTH-bit operands LSB-first at one bit per enabled
//   clock.
//
//   Subtraction is done as a + ~b + 1. B is inverted at capture, and the carry
//   is preset to 1 for a subtract.
//
//   Timeline, counting in enabled edges:
//     E0           : start is sampled in IDLE, and the operands are captured.
//     E1..EWIDTH   : one bit is processed per edge.
//     EWIDTH+1     : sum, cout and overflow are written, and done rises.
//     EWIDTH+2     : the block returns to IDLE.
//
// Ports
//   clk, rst_n      rising-edge clock; asynchronous active-low reset
//   ena             clock enable; when it is low, all state holds
//   start, sub      operation request and add/sub select (sampled in IDLE)
//   a, b            operands, captured with start
//   busy            high while the operation is in RUN
//   done            one enabled-cycle pulse when the result registers update
//   sum             result register, held until the next done
//   cout            carry out of the MSB (for subtract, 1 = no borrow)
//   overflow        signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------

// Single-bit full-adder slice: the combinational core of the serial datapath.
module serial_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             msb_cin;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_nxt;

  serial_addsub_fa u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      msb_cin  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;  // this is the +1 of the two's-complement subtract
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (cnt == CW'(WIDTH)) begin
            // All bits have been processed, so publish the result registers
            // together with done.
            sum      <= res;
            cout     <= carry;
            overflow <= msb_cin ^ carry;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            // The sum bit enters at the MSB. After WIDTH shifts, bit 0 has
            // reached the LSB.
            res   <= {s_bit, res[WIDTH-1:1]};
            carry <= c_nxt;
            cnt   <= cnt + CW'(1);
            // The carry going into the MSB slice is needed for the signed
            // overflow flag.
            if (cnt == CW'(WIDTH - 1)) msb_cin <= carry;
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
